// File: rtl/decode_pipe.sv
// decode_pipe: registered decode stage (control, immediates, forwarding, branch compare, D/E reg).
// Define DECODE_SKID_EN to add a 1-entry skid buffer that breaks the out_ready -> in_ready path.

package decode_pipe_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            regwrite;
        logic            memwrite;
        logic            memread;
        logic            imemwrite;
        logic            branchjump;
        logic [1:0]      branchop;
        logic [1:0]      src0sel;
        logic [1:0]      src1sel;
        logic [3:0]      aluop;
        logic [5:0]      rs0;
        logic [5:0]      rs1;
        logic [5:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } inst_t;

    typedef struct packed {
        inst_t           inst;
        logic [XLEN-1:0] rdata0;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] src0;
        logic [XLEN-1:0] src1;
        logic            taken;
    } stage_t;
endpackage

module decode_pipe #(
    // XLEN must match decode_pipe_pkg::XLEN, which sizes the pc/imm fields of inst_t.
    parameter int unsigned XLEN = decode_pipe_pkg::XLEN,
    parameter int unsigned NFWD = 2,
    localparam int unsigned SELW = $clog2(NFWD + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_instr,
    output logic [5:0]             rs0,
    output logic [5:0]             rs1,
    input  logic [XLEN-1:0]        rs0data,
    input  logic [XLEN-1:0]        rs1data,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [SELW-1:0]        fwd_sel0,
    input  logic [SELW-1:0]        fwd_sel1,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output decode_pipe_pkg::inst_t out_inst,
    output logic [XLEN-1:0]        out_rdata0,
    output logic [XLEN-1:0]        out_rdata1,
    output logic [XLEN-1:0]        out_src0,
    output logic [XLEN-1:0]        out_src1,
    output logic                   out_taken
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImem   = 7'b0001011;
    localparam logic [6:0] OpAluI   = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAlu    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    // Bank flag of the 6-bit register address; this core only has the integer bank.
    localparam logic IntBank = 1'b0;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    decode_pipe_pkg::inst_t  dec;
    decode_pipe_pkg::stage_t front;
    logic [XLEN-1:0] rdata0, rdata1, src0, src1;
    logic eq, lt, is_unsigned, taken;
    logic hazard, fire_in;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rs0    = {IntBank, in_instr[19:15]};
    assign rs1    = {IntBank, in_instr[24:20]};

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        imm32        = imm_i;
        dec.rs0      = rs0;
        dec.rs1      = rs1;
        dec.rd       = {IntBank, in_instr[11:7]};
        dec.pc       = in_pc;
        dec.branchop = {funct3[2], funct3[0]};
        case (opcode)
            OpAlu: begin
                dec.regwrite = 1'b1;
                dec.aluop    = {in_instr[30], funct3};
            end
            OpAluI: begin
                dec.regwrite = 1'b1;
                dec.src1sel  = 2'd2;
                dec.aluop    = {(funct3 == 3'b101) && in_instr[30], funct3};
            end
            OpLoad: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.src1sel  = 2'd2;
            end
            OpStore: begin
                dec.memwrite = 1'b1;
                dec.src1sel  = 2'd2;
                imm32        = imm_s;
            end
            OpImem: begin
                dec.imemwrite = 1'b1;
                dec.src1sel   = 2'd2;
                imm32         = imm_s;
            end
            OpBranch: begin
                // ALU computes the target pc+imm; the compare runs on the register operands.
                dec.branchjump = 1'b1;
                dec.src0sel    = 2'd2;
                dec.src1sel    = 2'd2;
                imm32          = imm_b;
            end
            OpJal, OpJalr: begin
                dec.regwrite   = 1'b1;
                dec.branchjump = 1'b1;
                dec.src0sel    = 2'd2;
                dec.src1sel    = 2'd1;
                imm32          = (opcode == OpJal) ? imm_j : imm_i;
            end
            OpLui, OpAuipc: begin
                dec.regwrite = 1'b1;
                dec.src0sel  = (opcode == OpLui) ? 2'd1 : 2'd2;
                dec.src1sel  = 2'd2;
                imm32        = imm_u;
            end
            default: ;
        endcase
        dec.imm = imm32;
    end

    // Select k (1..NFWD) picks source k-1; 0 and out-of-range selects fall back to the regfile.
    always_comb begin
        rdata0 = rs0data;
        rdata1 = rs1data;
        for (int k = 0; k < NFWD; k++) begin
            if (fwd_sel0 == SELW'(k + 1)) rdata0 = fwd_data[k*XLEN +: XLEN];
            if (fwd_sel1 == SELW'(k + 1)) rdata1 = fwd_data[k*XLEN +: XLEN];
        end
    end

    always_comb begin
        case (dec.src0sel)
            2'd0:    src0 = rdata0;
            2'd2:    src0 = in_pc;
            default: src0 = '0;
        endcase
        case (dec.src1sel)
            2'd0:    src1 = rdata1;
            2'd1:    src1 = XLEN'(4);
            2'd2:    src1 = dec.imm;
            default: src1 = '0;
        endcase
    end

    assign is_unsigned = (opcode == OpBranch) && in_instr[13];
    assign eq = (rdata0 == rdata1);
    assign lt = is_unsigned ? (rdata0 < rdata1) : ($signed(rdata0) < $signed(rdata1));

    always_comb begin
        case (dec.branchop)
            2'b00:   taken = eq;
            2'b01:   taken = !eq;
            2'b10:   taken = lt;
            default: taken = !lt;
        endcase
    end

    always_comb begin
        front        = '0;
        front.inst   = dec;
        front.rdata0 = rdata0;
        front.rdata1 = rdata1;
        front.src0   = src0;
        front.src1   = src1;
        front.taken  = taken;
    end

    function automatic logic load_use(input decode_pipe_pkg::inst_t e, input logic [5:0] a,
                                      input logic [5:0] b);
        return e.memread && (e.rd != 6'd0) && ((e.rd == a) || (e.rd == b));
    endfunction

    decode_pipe_pkg::stage_t out_q, out_d;
    logic out_valid_q, out_valid_d, out_load;

    assign fire_in = in_valid && in_ready;

`ifdef DECODE_SKID_EN
    decode_pipe_pkg::stage_t skid_q;
    logic skid_valid_q, skid_valid_d, skid_load;

    assign hazard = (out_valid_q && load_use(out_q.inst, rs0, rs1)) ||
                    (skid_valid_q && load_use(skid_q.inst, rs0, rs1));
    assign in_ready = !skid_valid_q && !hazard && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = front;
        out_load     = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_load    = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_load     = 1'b1;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_load    = fire_in;
                out_valid_d = fire_in;
            end
        end else if (fire_in) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            if (skid_load) skid_q <= front;
        end
    end
`else
    assign hazard   = out_valid_q && load_use(out_q.inst, rs0, rs1);
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;

    always_comb begin
        out_d    = front;
        out_load = fire_in;
        if (flush)          out_valid_d = 1'b0;
        else if (fire_in)   out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q              <= 1'b0;
            out_q.inst.regwrite      <= 1'b0;
            out_q.inst.memwrite      <= 1'b0;
            out_q.inst.memread       <= 1'b0;
            out_q.inst.imemwrite     <= 1'b0;
            out_q.inst.branchjump    <= 1'b0;
            out_q.taken              <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (out_load) out_q <= out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_inst   = out_q.inst;
    assign out_rdata0 = out_q.rdata0;
    assign out_rdata1 = out_q.rdata1;
    assign out_src0   = out_q.src0;
    assign out_src1   = out_q.src1;
    assign out_taken  = out_q.taken;
endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: vector table plus hazard, stall, flush and reset sequences.
// Expectations follow DECODE_SKID_EN when the bench is built with it.
module tb_decode_pipe;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NFWD = 4;
    localparam int unsigned SELW = 3;
    localparam int NV = 17;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, flush, out_valid, out_ready, out_taken;
    logic [XLEN-1:0] in_pc, rs0data, rs1data, out_rdata0, out_rdata1, out_src0, out_src1;
    logic [31:0] in_instr;
    logic [5:0] rs0, rs1;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [SELW-1:0] fwd_sel0, fwd_sel1;
    decode_pipe_pkg::inst_t out_inst;

    decode_pipe #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .rs0(rs0), .rs1(rs1), .rs0data(rs0data), .rs1data(rs1data),
        .fwd_data(fwd_data), .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_rdata0(out_rdata0), .out_rdata1(out_rdata1), .out_src0(out_src0),
        .out_src1(out_src1), .out_taken(out_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr, pc, d0, d1;
        logic [2:0]  s0, s1;
        logic [31:0] r0, r1, src0, src1;
        logic        taken;
        logic [4:0]  ctrl;  // {regwrite, memwrite, memread, imemwrite, branchjump}
    } vec_t;

    vec_t vecs [NV];
    int errors = 0;
    int checks = 0;
`ifdef DECODE_SKID_EN
    localparam bit Skid = 1'b1;
`else
    localparam bit Skid = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ctrl_bits();
        return {out_inst.regwrite, out_inst.memwrite, out_inst.memread, out_inst.imemwrite,
                out_inst.branchjump};
    endfunction

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_rdata0", i), out_rdata0, v.r0);
        check($sformatf("v%0d_rdata1", i), out_rdata1, v.r1);
        check($sformatf("v%0d_src0", i), out_src0, v.src0);
        check($sformatf("v%0d_src1", i), out_src1, v.src1);
        check($sformatf("v%0d_taken", i), 32'(out_taken), 32'(v.taken));
        check($sformatf("v%0d_ctrl", i), 32'(ctrl_bits()), 32'(v.ctrl));
        check($sformatf("v%0d_pc", i), out_inst.pc, v.pc);
    endtask

    task automatic present(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc = 32'h0;
        rs0data = 32'h0;
        rs1data = 32'h0;
        fwd_sel0 = 3'd0;
        fwd_sel1 = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] prog [3];
        logic [31:0] got [$];
        int idx, acc_stall;

        vecs[0]  = '{32'h00500093, 32'h000, 32'h0, 32'h7, 3'd0, 3'd0,
                     32'h0, 32'h7, 32'h000, 32'h5, 1'b0, 5'b10000};
        vecs[1]  = '{32'h00208463, 32'h004, 32'h5, 32'h5, 3'd0, 3'd0,
                     32'h5, 32'h5, 32'h004, 32'h8, 1'b1, 5'b00001};
        vecs[2]  = '{32'h0020E463, 32'h008, 32'hFFFFFFFF, 32'h1, 3'd0, 3'd0,
                     32'hFFFFFFFF, 32'h1, 32'h008, 32'h8, 1'b0, 5'b00001};
        vecs[3]  = '{32'h0020C463, 32'h00C, 32'hFFFFFFFF, 32'h1, 3'd0, 3'd0,
                     32'hFFFFFFFF, 32'h1, 32'h00C, 32'h8, 1'b1, 5'b00001};
        vecs[4]  = '{32'h0020F463, 32'h010, 32'hFFFFFFFF, 32'h1, 3'd0, 3'd0,
                     32'hFFFFFFFF, 32'h1, 32'h010, 32'h8, 1'b1, 5'b00001};
        vecs[5]  = '{32'h0020D463, 32'h014, 32'hFFFFFFFF, 32'h1, 3'd0, 3'd0,
                     32'hFFFFFFFF, 32'h1, 32'h014, 32'h8, 1'b0, 5'b00001};
        vecs[6]  = '{32'h00209463, 32'h018, 32'h3, 32'h3, 3'd0, 3'd0,
                     32'h3, 32'h3, 32'h018, 32'h8, 1'b0, 5'b00001};
        vecs[7]  = '{32'h002081B3, 32'h01C, 32'hAAAA, 32'hBBBB, 3'd3, 3'd0,
                     32'hDEADBEEF, 32'hBBBB, 32'hDEADBEEF, 32'hBBBB, 1'b0, 5'b10000};
        vecs[8]  = '{32'h002081B3, 32'h01C, 32'hAAAA, 32'hBBBB, 3'd5, 3'd1,
                     32'hAAAA, 32'h11111111, 32'hAAAA, 32'h11111111, 1'b0, 5'b10000};
        vecs[9]  = '{32'h002081B3, 32'h01C, 32'hAAAA, 32'hBBBB, 3'd4, 3'd7,
                     32'h44444444, 32'hBBBB, 32'h44444444, 32'hBBBB, 1'b0, 5'b10000};
        vecs[10] = '{32'h12345237, 32'h020, 32'h0, 32'h1, 3'd0, 3'd0,
                     32'h0, 32'h1, 32'h0, 32'h12345000, 1'b0, 5'b10000};
        vecs[11] = '{32'h00001217, 32'h100, 32'h0, 32'h0, 3'd0, 3'd0,
                     32'h0, 32'h0, 32'h100, 32'h1000, 1'b0, 5'b10000};
        vecs[12] = '{32'h010000EF, 32'h200, 32'h1, 32'h2, 3'd0, 3'd0,
                     32'h1, 32'h2, 32'h200, 32'h4, 1'b0, 5'b10001};
        vecs[13] = '{32'h0020A623, 32'h204, 32'h1000, 32'h9, 3'd0, 3'd0,
                     32'h1000, 32'h9, 32'h1000, 32'hC, 1'b0, 5'b01000};
        vecs[14] = '{32'h0020A60B, 32'h208, 32'h1000, 32'h9, 3'd0, 3'd0,
                     32'h1000, 32'h9, 32'h1000, 32'hC, 1'b0, 5'b00010};
        vecs[15] = '{32'hFFF00093, 32'h20C, 32'h0, 32'h0, 3'd0, 3'd0,
                     32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 5'b10000};
        vecs[16] = '{32'h00412383, 32'h210, 32'h50, 32'h0, 3'd0, 3'd0,
                     32'h50, 32'h0, 32'h50, 32'h4, 1'b0, 5'b10100};

        fwd_data = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        present(32'h0);
        in_valid = 1'b0;

        // Reset state.
        repeat (2) tick();
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_taken", 32'(out_taken), 32'd0);
        check("rst_ctrl", 32'(ctrl_bits()), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Back-to-back vector stream; outputs of vector i are checked while i+1 is presented.
        for (int i = 0; i < NV; i++) begin
            tick();
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
            rs0data = vecs[i].d0; rs1data = vecs[i].d1;
            fwd_sel0 = vecs[i].s0; fwd_sel1 = vecs[i].s1;
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("v%0d_rs0", i), 32'(rs0), 32'({1'b0, vecs[i].instr[19:15]}));
            check($sformatf("v%0d_rs1", i), 32'(rs1), 32'({1'b0, vecs[i].instr[24:20]}));
            if (i > 0) check_vec(i - 1, vecs[i-1]);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_vec(NV - 1, vecs[NV-1]);

        // Load-use: lw x5 then add x6,x5,x5 -> one bubble, add taken a cycle late.
        tick();
        present(32'h00002283);
        @(negedge clk);
        check("lu_lw_ready", 32'(in_ready), 32'd1);
        tick();
        present(32'h00528333);
        fwd_sel0 = 3'd1; fwd_sel1 = 3'd1;
        @(negedge clk);
        check("lu_hazard_ready", 32'(in_ready), 32'd0);
        check("lu_lw_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        check("lu_bubble", 32'(out_valid), 32'd0);
        check("lu_ready_after", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lu_add_valid", 32'(out_valid), 32'd1);
        check("lu_add_rd", 32'(out_inst.rd), 32'd6);
        check("lu_add_fwd", out_src0, 32'h11111111);
        tick();
        @(negedge clk);
        check("lu_no_dup", 32'(out_valid), 32'd0);

        // Load to x0 never interlocks.
        tick();
        present(32'h00002003);
        @(negedge clk);
        tick();
        present(32'h00000333);
        @(negedge clk);
        check("x0_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("x0_add_valid", 32'(out_valid), 32'd1);
        check("x0_add_rd", 32'(out_inst.rd), 32'd6);

        // Output stall for 3 cycles with input pending, then release.
        prog[0] = 32'h00100093; prog[1] = 32'h00200113; prog[2] = 32'h00300193;
        idx = 0; acc_stall = 0;
        tick();
        present(prog[0]);
        @(negedge clk);
        if (in_valid && in_ready) idx++;
        tick();
        out_ready = 1'b0;
        present(prog[idx]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_src1", c), out_src1, 32'd1);
            check($sformatf("stall%0d_ready", c), 32'(in_ready), 32'(Skid && c == 0));
            if (in_valid && in_ready) begin
                idx++;
                acc_stall++;
            end
            tick();
            if (idx < 3) present(prog[idx]);
            else in_valid = 1'b0;
        end
        check("stall_accepts", 32'(acc_stall), 32'(Skid));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_src1);
            if (in_valid && in_ready) idx++;
            tick();
            if (idx < 3) present(prog[idx]);
            else in_valid = 1'b0;
        end
        check("drain_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            check($sformatf("drain%0d", k), got[k], 32'(k + 1));
        @(negedge clk);
        check("drain_no_dup", 32'(out_valid), 32'd0);

        // Flush with a held entry (and a skid entry when the skid buffer exists).
        tick();
        present(prog[0]);
        @(negedge clk);
        tick();
        out_ready = 1'b0;
        present(prog[1]);
        @(negedge clk);
        tick();
        present(prog[2]);
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_out", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("flush_skid", 32'(out_valid), 32'd0);
        tick();
        present(32'h00400213);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        check("post_flush_src1", out_src1, 32'd4);
        tick();
        @(negedge clk);
        check("post_flush_idle", 32'(out_valid), 32'd0);

        // Reset asserted during a stall.
        tick();
        present(prog[0]);
        @(negedge clk);
        tick();
        out_ready = 1'b0;
        present(prog[1]);
        @(negedge clk);
        tick();
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_taken", 32'(out_taken), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        tick();
        @(negedge clk);
        check("midrst_skid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
